// File: rtl/qspi_arb.sv
// N-channel line-transfer arbiter in front of the single QSPI controller.
// Define QSPI_ARB_RR_EN for round-robin selection; otherwise lowest channel wins.
module qspi_arb #(
  parameter int NCH         = 2,
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  localparam int TW         = PA - $clog2(LINE_LENGTH),
  localparam int CW         = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    write,
  input  logic [NCH*TW-1:0] tag,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    done,
  output logic              m_req,
  output logic              m_write,
  output logic [TW-1:0]     m_tag,
  output logic [CW-1:0]     m_ch,
  output logic              m_mem,
  input  logic              m_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   lp, win;
  logic [NCH-1:0]  gnt_nx;
  logic [TW-1:0]   tag_sel;
  logic            write_sel;
  logic            grant_en, release_en;

  // winner selection over the live request vector
`ifdef QSPI_ARB_RR_EN
  int dist, best;
  always_comb begin
    win  = '0;
    dist = 0;
    best = NCH;
    for (int i = 0; i < NCH; i++) begin
      if (req[i]) begin
        // distance from the slot just after the last grant, wrapping
        dist = (i + NCH - 1 - int'(lp)) % NCH;
        if (dist < best) begin
          best = dist;
          win  = CW'(i);
        end
      end
    end
  end
`else
  logic unused_lp;
  assign unused_lp = ^lp;
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) win = CW'(i);
    end
  end
`endif

  always_comb begin
    tag_sel   = '0;
    write_sel = 1'b0;
    gnt_nx    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win == CW'(i)) begin
        tag_sel   = tag[i*TW +: TW];
        write_sel = write[i];
        gnt_nx[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_en   = 1'b0;
    release_en = 1'b0;
    done       = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (m_done) begin
          done       = gnt;
          release_en = 1'b1;
          state_nx   = RELEASE;
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant/attribute registers; attributes stay latched after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_tag   <= '0;
      m_ch    <= '0;
      lp      <= CW'(NCH - 1);
    end else begin
      state <= state_nx;
      if (grant_en) begin
        gnt     <= gnt_nx;
        m_req   <= 1'b1;
        m_write <= write_sel;
        m_tag   <= tag_sel;
        m_ch    <= win;
        lp      <= win;
      end else if (release_en) begin
        gnt   <= '0;
        m_req <= 1'b0;
      end
    end
  end

  assign m_mem = (m_tag[TW-1 -: 8] == 8'hff);

endmodule

// File: tb/tb_qspi_arb.sv
// Bench for qspi_arb: table vectors and corner sequences on a 2-channel
// instance, directed and randomized model checks on a 4-channel instance.
module tb_qspi_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // two-channel instance
  logic [1:0]  req2 = '0, wr2 = '0, gnt2, done2;
  logic [39:0] tag2 = '0;
  logic        md2 = 1'b0, m_req2, m_write2, m_mem2;
  logic [19:0] m_tag2;
  logic [0:0]  m_ch2;

  qspi_arb #(.NCH(2), .PA(22), .LINE_LENGTH(4)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .write(wr2), .tag(tag2),
    .gnt(gnt2), .done(done2), .m_req(m_req2), .m_write(m_write2),
    .m_tag(m_tag2), .m_ch(m_ch2), .m_mem(m_mem2), .m_done(md2));

  // four-channel instance
  logic [3:0]  req4 = '0, wr4 = '0, gnt4, done4;
  logic [79:0] tag4 = '0;
  logic        md4 = 1'b0, m_req4, m_write4, m_mem4;
  logic [19:0] m_tag4;
  logic [1:0]  m_ch4;

  qspi_arb #(.NCH(4), .PA(22), .LINE_LENGTH(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .write(wr4), .tag(tag4),
    .gnt(gnt4), .done(done4), .m_req(m_req4), .m_write(m_write4),
    .m_tag(m_tag4), .m_ch(m_ch4), .m_mem(m_mem4), .m_done(md4));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // view of whichever instance a directed sequence is driving
  logic       sel4 = 1'b0;
  logic       v_mreq;
  logic [3:0] v_gnt, v_done;
  logic [1:0] v_ch;
  always_comb begin
    if (sel4) begin
      v_mreq = m_req4; v_gnt = gnt4; v_done = done4; v_ch = m_ch4;
    end else begin
      v_mreq = m_req2; v_gnt = {2'b00, gnt2}; v_done = {2'b00, done2}; v_ch = {1'b0, m_ch2};
    end
  end

  task automatic set_md(input logic v);
    if (sel4) md4 = v;
    else md2 = v;
  endtask

  // one complete transfer on the selected instance: wait for grant, hold, complete
  task automatic xfer(input int exp_ch, input int exp_gap, input int hold);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      set_md(1'b0);
      mid();
      if (v_mreq) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    chk("xfer_grant_seen", 80'(ok), 80'(1));
    if (exp_gap >= 0) chk("xfer_gap", 80'(n), 80'(exp_gap));
    chk("xfer_gnt", 80'(v_gnt), 80'(1) << exp_ch);
    chk("xfer_m_ch", 80'(v_ch), 80'(exp_ch));
    for (int i = 0; i < hold; i++) begin
      next_cyc();
      mid();
      chk("xfer_hold", 80'(v_mreq), 80'(1));
    end
    next_cyc();
    set_md(1'b1);
    mid();
    chk("xfer_done", 80'(v_done), 80'(1) << exp_ch);
    next_cyc();
    set_md(1'b0);
    mid();
    chk("xfer_release", {75'd0, v_mreq, v_gnt}, 80'(0));
  endtask

  typedef struct {
    logic [1:0]  req, wr;
    logic [19:0] t0, t1;
    logic        md;
    logic [1:0]  gnt, done;
    logic        mreq;
    logic [19:0] tag;
    logic        mwr, ch, mem;
  } vec_t;
  vec_t tbl[14];

  // behavioural reference for the 4-channel instance
  int          m_cur, m_cool, m_last, m_chl;
  logic [19:0] m_tagl;
  logic        m_wrl;

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef QSPI_ARB_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (r[2'((last + k) % 4)]) return (last + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_cool = 0; m_last = 3; m_chl = 0; m_tagl = '0; m_wrl = 1'b0;
  endtask

  task automatic model_step();
    int w;
    if (m_cur >= 0) begin
      if (md4) begin
        m_cur  = -1;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req4 != 4'd0) begin
      w      = pick(req4, m_last);
      m_cur  = w;
      m_chl  = w;
      m_last = w;
      m_tagl = 20'(tag4 >> (w * 20));
      m_wrl  = wr4[2'(w)];
    end
  endtask

  initial begin
    logic [3:0]  eg;
    logic [19:0] t;
    bit          rst;
    int          exp_ch;

    tbl[0]  = '{2'b01, 2'b00, 20'h3fc01, 20'h00000, 1'b0, 2'b00, 2'b00, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 20'h3fc01, 20'h00000, 1'b0, 2'b01, 2'b00, 1'b1, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 20'h12345, 20'h00000, 1'b0, 2'b01, 2'b00, 1'b1, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 2'b11, 20'h12345, 20'h00000, 1'b0, 2'b01, 2'b00, 1'b1, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 20'h12345, 20'h00000, 1'b0, 2'b01, 2'b00, 1'b1, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 20'h12345, 20'h00000, 1'b1, 2'b01, 2'b01, 1'b1, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b00, 2'b00, 20'h12345, 20'h00000, 1'b1, 2'b00, 2'b00, 1'b0, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 2'b10, 20'h12345, 20'hff123, 1'b0, 2'b00, 2'b00, 1'b0, 20'h3fc01, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b10, 2'b00, 20'h12345, 20'h00abc, 1'b0, 2'b10, 2'b00, 1'b1, 20'hff123, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 20'h12345, 20'h00abc, 1'b0, 2'b10, 2'b00, 1'b1, 20'hff123, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{2'b10, 2'b00, 20'h12345, 20'h00abc, 1'b1, 2'b10, 2'b10, 1'b1, 20'hff123, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 20'h12345, 20'h00abc, 1'b0, 2'b00, 2'b00, 1'b0, 20'hff123, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{2'b00, 2'b00, 20'h12345, 20'h00abc, 1'b1, 2'b00, 2'b00, 1'b0, 20'hff123, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{2'b00, 2'b00, 20'h12345, 20'h00abc, 1'b0, 2'b00, 2'b00, 1'b0, 20'hff123, 1'b1, 1'b1, 1'b1};

    // reset values
    @(posedge clk);
    mid();
    chk("rst_gnt", 80'(gnt2), 80'(0));
    chk("rst_m_req", 80'(m_req2), 80'(0));
    chk("rst_m_tag", 80'(m_tag2), 80'(0));
    chk("rst_m_ch", 80'(m_ch2), 80'(0));
    chk("rst_m_write", 80'(m_write2), 80'(0));
    chk("rst_done", 80'(done2), 80'(0));
    chk("rst_gnt4", 80'(gnt4), 80'(0));
    next_cyc();
    reset = 1'b0;

    // table vectors on the 2-channel instance
    for (int i = 0; i < 14; i++) begin
      next_cyc();
      req2 = tbl[i].req; wr2 = tbl[i].wr; tag2 = {tbl[i].t1, tbl[i].t0}; md2 = tbl[i].md;
      mid();
      chk($sformatf("vec%0d_gnt", i), 80'(gnt2), 80'(tbl[i].gnt));
      chk($sformatf("vec%0d_done", i), 80'(done2), 80'(tbl[i].done));
      chk($sformatf("vec%0d_m_req", i), 80'(m_req2), 80'(tbl[i].mreq));
      chk($sformatf("vec%0d_m_tag", i), 80'(m_tag2), 80'(tbl[i].tag));
      chk($sformatf("vec%0d_m_write", i), 80'(m_write2), 80'(tbl[i].mwr));
      chk($sformatf("vec%0d_m_ch", i), 80'(m_ch2), 80'(tbl[i].ch));
      chk($sformatf("vec%0d_m_mem", i), 80'(m_mem2), 80'(tbl[i].mem));
    end

    // both channels requesting through three transfers
    sel4 = 1'b0;
    next_cyc();
    req2 = 2'b11; wr2 = 2'b01; tag2 = {20'hff555, 20'h0aaaa};
    for (int k = 0; k < 3; k++) begin
`ifdef QSPI_ARB_RR_EN
      exp_ch = k % 2;
`else
      exp_ch = 0;
`endif
      xfer(exp_ch, (k == 0) ? -1 : 1, 2);
    end
    next_cyc();
    req2 = 2'b00;

    // requester drops mid-transfer
    next_cyc();
    req2 = 2'b01;
    next_cyc();
    mid();
    chk("drop_gnt", 80'(gnt2), 80'(1));
    next_cyc();
    req2 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("drop_hold_m_req", 80'(m_req2), 80'(1));
      chk("drop_hold_gnt", 80'(gnt2), 80'(1));
      next_cyc();
    end
    md2 = 1'b1;
    mid();
    chk("drop_done", 80'(done2), 80'(1));
    next_cyc();
    md2 = 1'b0;
    mid();
    chk("drop_release", 80'(m_req2), 80'(0));

    // reset asserted mid-transfer
    next_cyc();
    req2 = 2'b01;
    next_cyc();
    mid();
    chk("rstbusy_pre_gnt", 80'(gnt2), 80'(1));
    next_cyc();
    #1 reset = 1'b1;
    #1;
    chk("rstbusy_gnt", 80'(gnt2), 80'(0));
    chk("rstbusy_m_req", 80'(m_req2), 80'(0));
    chk("rstbusy_m_tag", 80'(m_tag2), 80'(0));
    next_cyc();
    reset = 1'b0;
    req2 = 2'b10;
    mid();
    chk("rstbusy_idle_gnt", 80'(gnt2), 80'(0));
    next_cyc();
    mid();
    chk("rstbusy_new_gnt", 80'(gnt2), 80'(2));
    next_cyc();
    md2 = 1'b1;
    mid();
    chk("rstbusy_done", 80'(done2), 80'(2));
    next_cyc();
    md2 = 1'b0;
    req2 = 2'b00;

    // all four channels requesting through five transfers
    sel4 = 1'b1;
    next_cyc();
    req4 = 4'hf;
    for (int k = 0; k < 5; k++) begin
`ifdef QSPI_ARB_RR_EN
      exp_ch = k % 4;
`else
      exp_ch = 0;
`endif
      xfer(exp_ch, (k == 0) ? -1 : 1, 1);
    end
    next_cyc();
    req4 = 4'h0;

    // randomized traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cyc();
      rst = (cyc == 0) || ($urandom_range(99) == 0);
      reset = rst;
      req4 = 4'($urandom_range(15));
      wr4 = 4'($urandom_range(15));
      md4 = ($urandom_range(3) == 0);
      for (int i = 0; i < 4; i++) begin
        t = 20'($urandom);
        if ($urandom_range(2) == 0) t[19:12] = 8'hff;
        tag4[i*20 +: 20] = t;
      end
      if (rst) model_reset();
      mid();
      eg = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
      chk("rnd_gnt", 80'(gnt4), 80'(eg));
      chk("rnd_done", 80'(done4), 80'((m_cur >= 0 && md4) ? eg : 4'b0000));
      chk("rnd_m_req", 80'(m_req4), 80'(m_cur >= 0));
      chk("rnd_m_tag", 80'(m_tag4), 80'(m_tagl));
      chk("rnd_m_write", 80'(m_write4), 80'(m_wrl));
      chk("rnd_m_ch", 80'(m_ch4), 80'(m_chl));
      chk("rnd_m_mem", 80'(m_mem4), 80'(m_tagl[19:12] == 8'hff));
      chk("rnd_onehot", 80'($onehot0(gnt4)), 80'(1));
      if (!rst) model_step();
    end
    next_cyc();
    reset = 1'b0;
    req4 = 4'h0;
    md4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_arb.md
# qspi_arb

Parametrised N-channel line-transfer arbiter between the cache miss engines and the single QSPI controller. It generalises the fixed two-way ifetch/data tag mux into NCH requesters with registered, one-hot grants and latched transaction attributes. Each granted transfer holds the controller until it completes. With `QSPI_ARB_RR_EN` the arbiter is fair round-robin; without it, it is fixed priority.

## Interface
Parameters:
- NCH, 2, number of requesting channels (channel 0 = icache, 1 = dcache, higher = future DMA/MMU walker); 2..8
- PA, 22, physical address width
- LINE_LENGTH, 4, cache line length in bytes; TW = PA - $clog2(LINE_LENGTH) is the tag width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NCH  per-channel line transfer request, level
- write  in  NCH  per-channel: 1 = push (write line), 0 = pull (read line)
- tag  in  NCH*TW  per-channel line tag; channel i occupies bits [i*TW +: TW]
- gnt  out  NCH  one-hot grant, registered
- done  out  NCH  per-channel completion pulse
- m_req  out  1  request to QSPI controller, registered
- m_write  out  1  latched write flag of the granted channel
- m_tag  out  TW  latched tag of the granted channel
- m_ch  out  $clog2(NCH)  index of the granted channel (steers strobe demux)
- m_mem  out  1  m_tag[TW-1:TW-8] == 8'hff (RAM chip-select vs flash)
- m_done  in  1  one-cycle pulse from the controller: line transfer finished

## Operation
FSM states: IDLE, BUSY, RELEASE.
- IDLE: gnt = 0, m_req = 0. If |req, select winner w. On the next edge: gnt[w] = 1, m_ch = w, m_tag = tag[w], m_write = write[w], m_req = 1; go BUSY.
- BUSY: m_req held at 1; m_tag, m_write and m_ch are frozen. Changes on req/tag/write of any channel are ignored. On m_done: done = gnt (combinational, same cycle). On the next edge: gnt = 0, m_req = 0; go RELEASE.
- RELEASE: one dead cycle so the completed requester can update its hit/req. Go IDLE unconditionally; no grant is issued in this cycle.
- A transfer cannot be aborted. If req[w] drops during BUSY, the arbiter stays BUSY until m_done, and done[w] still pulses.
- m_done outside BUSY is ignored; done stays 0.
- Winner selection is described under Configuration. A last-grant pointer lp (width $clog2(NCH)) updates to w on every grant.
- m_mem is combinational from m_tag.

## Timing
- Reset values: state = IDLE, gnt = 0, done = 0, m_req = 0, m_write = 0, m_tag = 0, m_ch = 0, lp = NCH-1 (so channel 0 is searched first).
- Reset is effective immediately, including mid-BUSY. Any in-flight transfer is dropped, and the controller is reset from the same signal.
- Request to grant: req sampled high in IDLE at edge k gives gnt and m_req high after edge k+1 (1 cycle).
- Back-to-back minimum: m_done at cycle c, then RELEASE at c+1, IDLE at c+2, next grant visible at c+3. Grant-to-grant is therefore at least 3 cycles plus the transfer.
- done is high for exactly one cycle, coincident with m_done.
- gnt has at most one bit set at all times.

## Configuration
Macro `QSPI_ARB_RR_EN`:
- Defined: round-robin. Search req starting at index (lp+1) mod NCH, wrapping; the first set bit wins. A continuously requesting channel is therefore served at most once per NCH grants when others are waiting.
- Undefined: fixed priority, lowest index wins (icache over dcache). lp is still maintained but not used.

## Test plan
- Reset during BUSY (req = 2'b01, assert reset mid-transfer) -> gnt = 0, m_req = 0 immediately. After release, req = 2'b10 -> gnt = 2'b10 one cycle later.
- Single request: req = 2'b01, tag0 = 20'h3fc01, write = 0 -> next cycle gnt = 01, m_req = 1, m_tag = 3fc01, m_mem = 0. m_done at +5 -> done = 01 the same cycle, m_req = 0 the cycle after.
- m_mem decode: tag1 = 20'hff123, write = 1 -> m_mem = 1, m_write = 1. Changing tag1 during BUSY leaves m_tag = ff123.
- Simultaneous requests, req = 2'b11 held through three transfers: with RR_EN, grant order is 0, 1, 0; without it, 0, 0, 0.
- NCH = 4, all req high, RR_EN: grants cycle 0, 1, 2, 3, 0. Grant-to-grant spacing = transfer length + 3 cycles.
- Stray m_done in IDLE -> done stays 0, no state change. req[0] dropped mid-BUSY -> m_req held until m_done, done[0] still pulses.
